// File: rtl/record_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : record_sequencer_if
//  Description : RAM bus between the record sequencer and its 64x10 note RAM.
//                master : sequencer (drives address, write enable, write data)
//                slave  : RAM (returns read data one cycle after the address)
//  Signals     : ram_addr [5:0], ram_wren, ram_wdata [9:0], ram_q [9:0]
//  Revision    : 1.0 - initial release
// ============================================================================
interface record_sequencer_if;
    logic [5:0] ram_addr;
    logic       ram_wren;
    logic [9:0] ram_wdata;
    logic [9:0] ram_q;

    modport master (
        output ram_addr,
        output ram_wren,
        output ram_wdata,
        input  ram_q
    );

    modport slave (
        input  ram_addr,
        input  ram_wren,
        input  ram_wdata,
        output ram_q
    );
endinterface
`default_nettype wire

// File: rtl/record_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : record_sequencer
//  Description : Records up to 64 switch note patterns into a RAM on beat
//                ticks and plays them back (optionally looping).
//  Ports       : clk, resetn (sync, active-low)
//                select, back      - button levels, acted on at rising edges
//                mode_sw[1:0]      - 00 record, 01 play
//                loop_en           - loop playback
//                beat_tick         - one-cycle beat strobe
//                note_in[9:0]      - note pattern to record
//                ram (master)      - RAM address / write / read-data bus
//                note_out[9:0], note_valid - playback output and update pulse
//                state[2:0], rec_len[6:0]  - status
//  Revision    : 1.0 - initial release
// ============================================================================
module record_sequencer (
    input  wire logic              clk,
    input  wire logic              resetn,
    input  wire logic              select,
    input  wire logic              back,
    input  wire logic [1:0]        mode_sw,
    input  wire logic              loop_en,
    input  wire logic              beat_tick,
    input  wire logic [9:0]        note_in,
    record_sequencer_if.master     ram,
    output logic      [9:0]        note_out,
    output logic                   note_valid,
    output logic      [2:0]        state,
    output logic      [6:0]        rec_len
);

    localparam logic [2:0] S_SELECT     = 3'd0;
    localparam logic [2:0] S_REC_ARM    = 3'd1;
    localparam logic [2:0] S_RECORDING  = 3'd2;
    localparam logic [2:0] S_PLAY_ARM   = 3'd3;
    localparam logic [2:0] S_PLAY       = 3'd4;
    localparam logic [2:0] S_PLAY_FETCH = 3'd5;
    localparam logic [2:0] S_DONE       = 3'd6;

    localparam logic [6:0] C_MAX_LEN    = 7'd64;

    logic       sel_q, back_q;
    // Low for the first cycle after reset so a button held through reset
    // release is not mistaken for a fresh press.
    logic       armed_q;
    logic [2:0] state_q, state_d;
    logic [5:0] addr_q, addr_d;
    logic [6:0] len_q, len_d;
    logic [9:0] note_q, note_d;
    logic       valid_q, valid_d;

    logic       w_sel_rise, w_back_rise, w_sel_act, w_any_edge, w_write;

    assign w_sel_rise  = armed_q & select & ~sel_q;
    assign w_back_rise = armed_q & back & ~back_q;
    // back wins when both buttons rise together
    assign w_sel_act   = w_sel_rise & ~w_back_rise;
    assign w_any_edge  = w_sel_rise | w_back_rise;
    // A button edge pre-empts a coincident beat; a full buffer never writes.
    assign w_write     = (state_q == S_RECORDING) & beat_tick & ~w_any_edge &
                         (len_q != C_MAX_LEN);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        note_d  = note_q;
        valid_d = 1'b0;
        case (state_q)
            S_SELECT: begin
                if (w_sel_act && mode_sw == 2'b00)
                    state_d = S_REC_ARM;
                else if (w_sel_act && mode_sw == 2'b01 && len_q != 7'd0)
                    state_d = S_PLAY_ARM;
            end
            S_REC_ARM: begin
                if (w_back_rise) begin
                    state_d = S_SELECT;
                end else if (w_sel_act) begin
                    state_d = S_RECORDING;
                    addr_d  = 6'd0;
                    len_d   = 7'd0;
                end
            end
            S_RECORDING: begin
                if (w_back_rise) begin
                    state_d = S_REC_ARM;
                    addr_d  = 6'd0;
                    len_d   = 7'd0;
                end else if (w_sel_act) begin
                    state_d = S_DONE;
                end else if (w_write) begin
                    // 6-bit address wraps to 0 naturally after slot 63
                    addr_d = addr_q + 6'd1;
                    len_d  = len_q + 7'd1;
                    if (len_q == C_MAX_LEN - 7'd1)
                        state_d = S_DONE;
                end
            end
            S_PLAY_ARM: begin
                if (w_back_rise) begin
                    state_d = S_SELECT;
                end else if (w_sel_act) begin
                    state_d = S_PLAY;
                    addr_d  = 6'd0;
                end
            end
            S_PLAY: begin
                if (w_any_edge)
                    state_d = S_SELECT;
                else if (beat_tick)
                    state_d = S_PLAY_FETCH;
            end
            S_PLAY_FETCH: begin
                // ram_q now reflects the address held during PLAY
                note_d  = ram.ram_q;
                valid_d = 1'b1;
                if (({1'b0, addr_q} + 7'd1) < len_q) begin
                    addr_d  = addr_q + 6'd1;
                    state_d = S_PLAY;
                end else if (loop_en) begin
                    addr_d  = 6'd0;
                    state_d = S_PLAY;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (w_any_edge)
                    state_d = S_SELECT;
            end
            default: state_d = S_SELECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sel_q   <= 1'b0;
            back_q  <= 1'b0;
            armed_q <= 1'b0;
            state_q <= S_SELECT;
            addr_q  <= 6'd0;
            len_q   <= 7'd0;
            note_q  <= 10'd0;
            valid_q <= 1'b0;
        end else begin
            sel_q   <= select;
            back_q  <= back;
            armed_q <= 1'b1;
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            note_q  <= note_d;
            valid_q <= valid_d;
        end
    end

    assign ram.ram_addr  = addr_q;
    assign ram.ram_wren  = w_write & resetn;
    assign ram.ram_wdata = note_in;
    assign note_out      = note_q;
    assign note_valid    = valid_q;
    assign state         = state_q;
    assign rec_len       = len_q;

endmodule
`default_nettype wire

// File: tb/tb_record_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_record_sequencer
//  Description : Self-checking bench for record_sequencer with a behavioural
//                RAM and a list of recorded notes as the playback reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_record_sequencer;

    logic       clk = 1'b0;
    logic       resetn, select, back, loop_en, beat_tick;
    logic [1:0] mode_sw;
    logic [9:0] note_in, note_out;
    logic       note_valid;
    logic [2:0] state;
    logic [6:0] rec_len;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int bad_wr = 0;

    logic [9:0] mem [64];
    logic [9:0] rec_vals [64];

    record_sequencer_if bus ();

    record_sequencer dut (
        .clk        (clk),
        .resetn     (resetn),
        .select     (select),
        .back       (back),
        .mode_sw    (mode_sw),
        .loop_en    (loop_en),
        .beat_tick  (beat_tick),
        .note_in    (note_in),
        .ram        (bus.master),
        .note_out   (note_out),
        .note_valid (note_valid),
        .state      (state),
        .rec_len    (rec_len)
    );

    always #10 clk = ~clk;

    // 64x10 RAM, one-cycle read latency
    always @(posedge clk) begin
        if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_q <= mem[bus.ram_addr];
    end

    always @(negedge clk) begin
        if (bus.ram_wren) begin
            wr_count++;
            if (state != 3'd2) bad_wr++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press_sel();
        select = 1'b1; cyc(); select = 1'b0; cyc();
    endtask

    task automatic press_back();
        back = 1'b1; cyc(); back = 1'b0; cyc();
    endtask

    task automatic rec_tick(input logic [9:0] v, input logic exp_wr, input logic [5:0] exp_addr);
        beat_tick = 1'b1;
        note_in   = v;
        @(negedge clk);
        check("rec_wren", bus.ram_wren, exp_wr);
        if (exp_wr) begin
            check("rec_addr", bus.ram_addr, exp_addr);
            check("rec_wdata", bus.ram_wdata, v);
        end
        cyc();
        beat_tick = 1'b0;
        repeat ($urandom_range(0, 2)) cyc();
    endtask

    task automatic play_tick(input logic [9:0] exp);
        beat_tick = 1'b1;
        cyc();
        beat_tick = 1'b0;
        check("fetch_state", state, 3'd5);
        check("fetch_novalid", note_valid, 1'b0);
        cyc();
        check("play_valid", note_valid, 1'b1);
        check("play_note", note_out, exp);
        cyc();
        check("valid_pulse", note_valid, 1'b0);
        repeat ($urandom_range(0, 2)) cyc();
    endtask

    initial begin
        int w0;
        logic [9:0] v;
        resetn = 1'b0; select = 1'b1; back = 1'b0; loop_en = 1'b0;
        beat_tick = 1'b0; mode_sw = 2'b00; note_in = 10'd0;
        for (int i = 0; i < 64; i++) mem[i] = 10'd0;
        repeat (3) cyc();
        check("rst_state", state, 3'd0);
        check("rst_addr", bus.ram_addr, 6'd0);
        check("rst_len", rec_len, 7'd0);
        check("rst_note", note_out, 10'd0);
        check("rst_valid", note_valid, 1'b0);
        check("rst_wren", bus.ram_wren, 1'b0);

        // select held through reset release must not act
        resetn = 1'b1;
        repeat (3) cyc();
        check("held_sel_no_edge", state, 3'd0);
        select = 1'b0; cyc();

        // play request with an empty recording
        mode_sw = 2'b01; press_sel();
        check("play_empty", state, 3'd0);

        // record three notes
        mode_sw = 2'b00; press_sel();
        check("rec_arm", state, 3'd1);
        press_sel();
        check("recording", state, 3'd2);
        check("rec_start_len", rec_len, 7'd0);
        w0 = wr_count;
        for (int k = 0; k < 3; k++) begin
            v = 10'(k + 1);
            rec_vals[k] = v;
            rec_tick(v, 1'b1, 6'(k));
        end
        press_sel();
        check("rec3_state", state, 3'd6);
        check("rec3_len", rec_len, 7'd3);
        check("rec3_writes", wr_count - w0, 3);
        rec_tick(10'h3ff, 1'b0, 6'd0);
        check("done_ignores_beat", state, 3'd6);

        // looped playback A,B,C,A,B
        press_back();
        check("done_to_select", state, 3'd0);
        mode_sw = 2'b01; press_sel();
        check("play_arm", state, 3'd3);
        press_sel();
        check("play", state, 3'd4);
        check("play_addr0", bus.ram_addr, 6'd0);
        loop_en = 1'b1;
        for (int k = 0; k < 5; k++) play_tick(rec_vals[k % 3]);
        check("loop_state", state, 3'd4);
        press_back();
        check("play_back", state, 3'd0);

        // non-looped playback ends in DONE after C
        loop_en = 1'b0;
        press_sel(); press_sel();
        for (int k = 0; k < 3; k++) play_tick(rec_vals[k]);
        check("noloop_done", state, 3'd6);
        press_back();

        // full memory with random notes, 70 beats
        mode_sw = 2'b00; press_sel(); press_sel();
        w0 = wr_count;
        for (int k = 0; k < 70; k++) begin
            v = 10'($urandom);
            if (k < 64) rec_vals[k] = v;
            rec_tick(v, k < 64, 6'(k));
            if (k == 63) check("full_done_at_64", state, 3'd6);
        end
        check("full_writes", wr_count - w0, 64);
        check("full_len", rec_len, 7'd64);
        check("full_state", state, 3'd6);
        check("full_addr_wrap", bus.ram_addr, 6'd0);

        // looped playback across the 64-slot boundary
        press_back(); mode_sw = 2'b01; press_sel(); press_sel();
        loop_en = 1'b1;
        for (int k = 0; k < 66; k++) play_tick(rec_vals[k % 64]);
        press_back();
        loop_en = 1'b0;

        // select + beat in RECORDING: stop without writing
        mode_sw = 2'b00; press_sel(); press_sel();
        rec_tick(10'h155, 1'b1, 6'd0);
        rec_tick(10'h0aa, 1'b1, 6'd1);
        select = 1'b1; beat_tick = 1'b1;
        @(negedge clk);
        check("sel_beat_nowren", bus.ram_wren, 1'b0);
        cyc(); select = 1'b0; beat_tick = 1'b0; cyc();
        check("sel_beat_state", state, 3'd6);
        check("sel_beat_len", rec_len, 7'd2);

        // select + back + beat in RECORDING
        press_back(); press_sel(); press_sel();
        rec_tick(10'h111, 1'b1, 6'd0);
        rec_tick(10'h222, 1'b1, 6'd1);
        select = 1'b1; back = 1'b1; beat_tick = 1'b1;
        @(negedge clk);
        check("simul_nowren", bus.ram_wren, 1'b0);
        cyc(); select = 1'b0; back = 1'b0; beat_tick = 1'b0; cyc();
        check("simul_state", state, 3'd1);
        check("simul_len", rec_len, 7'd0);

        // reset during PLAY_FETCH
        press_sel();
        rec_tick(10'h301, 1'b1, 6'd0);
        rec_tick(10'h302, 1'b1, 6'd1);
        press_sel(); press_back();
        mode_sw = 2'b01; press_sel(); press_sel();
        check("pre_rst_play", state, 3'd4);
        beat_tick = 1'b1; cyc(); beat_tick = 1'b0;
        check("pre_rst_fetch", state, 3'd5);
        resetn = 1'b0; cyc(); resetn = 1'b1;
        check("midrst_state", state, 3'd0);
        check("midrst_valid", note_valid, 1'b0);
        check("midrst_note", note_out, 10'd0);
        check("midrst_len", rec_len, 7'd0);
        check("midrst_addr", bus.ram_addr, 6'd0);
        check("midrst_wren", bus.ram_wren, 1'b0);
        cyc();
        check("midrst_novalid", note_valid, 1'b0);

        check("wren_outside_rec", bad_wr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
